rx_fifo_ctrl: RTL and testbench

RX_FIFO_CTRL -- requirements
Module: rx_fifo_ctrl

---
 rtl/rx_ctrl_pkg.sv | 19 +
 rtl/rx_fifo.sv | 69 ++++++
 rtl/rx_fifo_ctrl.sv | 117 +++++++++++
 tb/tb_rx_fifo_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_ctrl_pkg.sv
// Shared types for the receive FIFO controller:
// FSM states, default depth and the tagged FIFO entry.
package rx_ctrl_pkg;

    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        ACK,
        WAIT_CLR
    } state_e;

    typedef struct packed {
        logic       ferr;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/rx_fifo.sv
// Circular buffer of tagged receive bytes with occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module rx_fifo
    import rx_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push_i,
    input  entry_t                 wdata_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full buffer is only legal when a pop frees the slot.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rx_fifo_ctrl.sv
// Receive-side handshake FSM feeding a small FIFO, plus
// framing-error counter and sticky overrun flag.
module rx_fifo_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic [7:0]                  rx_data,
    input  logic                        data_ready,
    input  logic                        framing_error,
    input  logic                        overrun_error,
    output logic                        data_read,
    input  logic                        pop,
    input  logic                        clr_err,
    output logic [7:0]                  out_data,
    output logic                        out_ferr,
    output logic                        out_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [7:0]                  ferr_count,
    output logic                        overrun_seen
);

    state_e     state_q;
    entry_t     entry_q;
    entry_t     head;
    logic       push_q;
    logic       data_read_q;
    logic       full;
    logic       empty;
    logic [7:0] ferr_cnt_q;
    logic [7:0] ferr_cnt_d;
    logic       ovr_q;
    logic       ovr_d;

    rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push_i  (push_q),
        .wdata_i (entry_q),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    // Byte is latched in CAPTURE and written on the following edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            entry_q     <= '0;
            push_q      <= 1'b0;
            data_read_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            data_read_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (data_ready && !full) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    entry_q.ferr <= framing_error;
                    entry_q.data <= rx_data;
                    push_q       <= 1'b1;
                    state_q      <= ACK;
                end
                ACK: begin
                    data_read_q <= 1'b1;
                    state_q     <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    if (!data_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ferr_cnt_d = ferr_cnt_q;
        if (clr_err) begin
            ferr_cnt_d = '0;
        end else if (state_q == CAPTURE && framing_error
                     && ferr_cnt_q != 8'hFF) begin
            ferr_cnt_d = ferr_cnt_q + 8'd1;
        end
    end

    // A new overrun beats a simultaneous clear.
    assign ovr_d = overrun_error || (ovr_q && !clr_err);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ferr_cnt_q <= '0;
            ovr_q      <= 1'b0;
        end else begin
            ferr_cnt_q <= ferr_cnt_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data_read    = data_read_q;
    assign out_data     = head.data;
    assign out_ferr     = head.ferr;
    assign out_valid    = !empty;
    assign ferr_count   = ferr_cnt_q;
    assign overrun_seen = ovr_q;

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Directed bench for rx_fifo_ctrl: handshake latency, ordering,
// backpressure, error counters and asynchronous reset.
module tb_rx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       data_ready = 1'b0;
    logic       framing_error = 1'b0;
    logic       overrun_error = 1'b0;
    logic       data_read;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] out_data;
    logic       out_ferr;
    logic       out_valid;
    logic [2:0] fifo_count;
    logic [7:0] ferr_count;
    logic       overrun_seen;

    int n_cmp = 0;
    int n_err = 0;

    rx_fifo_ctrl #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .data_read     (data_read),
        .pop           (pop),
        .clr_err       (clr_err),
        .out_data      (out_data),
        .out_ferr      (out_ferr),
        .out_valid     (out_valid),
        .fifo_count    (fifo_count),
        .ferr_count    (ferr_count),
        .overrun_seen  (overrun_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the acknowledge, then release data_ready.
    task automatic wait_ack(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (data_read) seen = 1'b1;
        end
        chk({tag, "_ack"}, 32'(seen), 1);
        data_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_one"}, 32'(data_read), 0);
    endtask

    task automatic send(input logic [7:0] d, input logic fe,
                        input string tag);
        rx_data       = d;
        framing_error = fe;
        data_ready    = 1'b1;
        wait_ack(tag);
        framing_error = 1'b0;
    endtask

    task automatic pop_one();
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
    endtask

    initial begin
        bit any;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_dread", 32'(data_read), 0);
        chk("rst_ferrc", 32'(ferr_count), 0);
        chk("rst_ovr", 32'(overrun_seen), 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Single byte latency
        rx_data    = 8'hA5;
        data_ready = 1'b1;
        @(negedge clk);
        chk("lat_n_dread", 32'(data_read), 0);
        chk("lat_n_valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_n1_dread", 32'(data_read), 0);
        chk("lat_n1_valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_n2_dread", 32'(data_read), 1);
        chk("lat_n2_valid", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 32'hA5);
        chk("lat_ferr", 32'(out_ferr), 0);
        chk("lat_count", 32'(fifo_count), 1);
        data_ready = 1'b0;
        @(negedge clk);
        chk("lat_dread_off", 32'(data_read), 0);
        pop_one();
        chk("lat_pop_valid", 32'(out_valid), 0);
        chk("lat_pop_count", 32'(fifo_count), 0);

        // Fill to full, backpressure on fifth byte
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, "fill");
        chk("full_count", 32'(fifo_count), 4);
        chk("full_head", 32'(out_data), 32'h01);
        rx_data    = 8'h05;
        data_ready = 1'b1;
        any = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any |= data_read;
        end
        chk("full_no_ack", 32'(any), 0);
        chk("full_hold", 32'(fifo_count), 4);
        pop_one();
        wait_ack("fifth");
        chk("fifth_count", 32'(fifo_count), 4);
        for (int i = 2; i <= 5; i++) begin
            chk("order", 32'(out_data), 32'(i));
            pop_one();
        end
        chk("order_empty", 32'(out_valid), 0);

        // Push and pop on the same edge
        send(8'h10, 1'b0, "pp0");
        send(8'h11, 1'b0, "pp1");
        send(8'h12, 1'b0, "pp2");
        rx_data    = 8'h13;
        data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        chk("pp_dread", 32'(data_read), 1);
        chk("pp_count", 32'(fifo_count), 3);
        chk("pp_head", 32'(out_data), 32'h11);
        data_ready = 1'b0;
        @(negedge clk);
        for (int i = 8'h11; i <= 8'h13; i++) begin
            chk("pp_order", 32'(out_data), 32'(i));
            pop_one();
        end
        chk("pp_empty", 32'(fifo_count), 0);
        pop_one();
        chk("pop_empty_count", 32'(fifo_count), 0);
        chk("pop_empty_valid", 32'(out_valid), 0);
        send(8'h77, 1'b0, "after_empty_pop");
        chk("aep_data", 32'(out_data), 32'h77);
        chk("aep_count", 32'(fifo_count), 1);
        pop_one();

        // Framing-error tagging and saturation
        send(8'h3C, 1'b1, "fe");
        chk("fe_tag", 32'(out_ferr), 1);
        chk("fe_data", 32'(out_data), 32'h3C);
        chk("fe_cnt1", 32'(ferr_count), 1);
        pop_one();
        for (int i = 2; i <= 255; i++) begin
            send(8'h3C, 1'b1, "fe_loop");
            pop_one();
        end
        chk("fe_cnt255", 32'(ferr_count), 255);
        send(8'h3C, 1'b1, "fe_sat");
        pop_one();
        chk("fe_sat", 32'(ferr_count), 255);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("fe_clr", 32'(ferr_count), 0);

        // Sticky overrun, set beats clear
        clr_err       = 1'b1;
        overrun_error = 1'b1;
        @(negedge clk);
        overrun_error = 1'b0;
        chk("ovr_set_wins", 32'(overrun_seen), 1);
        @(negedge clk);
        clr_err = 1'b0;
        chk("ovr_clr", 32'(overrun_seen), 0);
        overrun_error = 1'b1;
        @(negedge clk);
        overrun_error = 1'b0;
        @(negedge clk);
        chk("ovr_sticky", 32'(overrun_seen), 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("ovr_clr2", 32'(overrun_seen), 0);

        // Asynchronous reset while in ACK with two entries stored
        send(8'h21, 1'b0, "rs0");
        send(8'h22, 1'b0, "rs1");
        chk("rs_count2", 32'(fifo_count), 2);
        rx_data    = 8'h23;
        data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_rst      = 1'b0;
        data_ready = 1'b0;
        #1;
        chk("rs_valid", 32'(out_valid), 0);
        chk("rs_count", 32'(fifo_count), 0);
        chk("rs_dread", 32'(data_read), 0);
        @(negedge clk);
        n_rst = 1'b1;
        any = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any |= data_read;
        end
        chk("rs_no_ack", 32'(any), 0);
        chk("rs_still_empty", 32'(fifo_count), 0);
        send(8'h44, 1'b0, "rs_fresh");
        chk("rs_fresh_data", 32'(out_data), 32'h44);
        chk("rs_fresh_count", 32'(fifo_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
